hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Detects hazards that operand forwarding cannot resolve:
  - load-use in EX;
  - ID-stage branch compare needing an in-flight result;
  - external memory wait.
- Sequences multi-cycle stalls with a small FSM and drives the PC / IF_ID / ID_EX write-enable and flush controls.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of the stall_cycles performance counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- if_id_rs  input  5  rs field of the instruction in ID
- if_id_rt  input  5  rt field of the instruction in ID
- if_id_uses_rs  input  1  ID instruction reads rs
- if_id_uses_rt  input  1  ID instruction reads rt
- if_id_is_branch  input  1  ID instruction is beq/bne (compare done in ID)
- id_ex_rd  input  5  destination register of the instruction in EX
- id_ex_mem_read  input  1  EX instruction is a load
- id_ex_reg_write  input  1  EX instruction writes a register
- ex_mem_rd  input  5  destination register of the instruction in MEM
- ex_mem_mem_read  input  1  MEM instruction is a load
- branch_taken  input  1  ID branch resolved taken
- jump  input  1  ID instruction is j/jal/jr
- mem_busy  input  1  data/instruction memory not ready this cycle
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF_ID register load enable
- if_id_flush  output  1  zero IF_ID (squash fetched instruction)
- id_ex_flush  output  1  insert bubble into ID_EX (control bits zeroed)
- pipe_freeze  output  1  hold every pipeline register, no bubble
- stall_active  output  1  a hazard stall is in progress this cycle
- stall_cycles  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Match definitions (register 0 never matches):
  - mEX = id_ex_rd != 0 and ((if_id_uses_rs and if_id_rs == id_ex_rd) or (if_id_uses_rt and if_id_rt == id_ex_rd)).
  - mMEM: the same test against ex_mem_rd.
- Hazard classes, evaluated in RUN only:
  - H2, 2 bubbles: if_id_is_branch and id_ex_mem_read and mEX.
  - H1, 1 bubble, any of:
    - id_ex_mem_read and mEX (load-use);
    - if_id_is_branch and id_ex_reg_write and mEX;
    - if_id_is_branch and ex_mem_mem_read and mMEM.
  - H2 takes precedence over H1.
- FSM states:
  - RUN: when H1 or H2 is detected, stall outputs assert in the same cycle (combinational).
    - H1: next state RUN (the 1 bubble is complete).
    - H2: next state STALL, rem <= 1.
  - STALL: stall outputs asserted; hazard detection ignored.
    - rem decrements each cycle.
    - Next state RUN when rem == 0 after the decrement. H2 therefore gives exactly 2 consecutive bubbles.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, stall_active=1.
- No stall, RUN: pc_write=1, if_id_write=1, id_ex_flush=0, stall_active=0.
  - if_id_flush = branch_taken or jump, for one cycle per assertion.
- branch_taken/jump are ignored (if_id_flush=0) whenever a stall is asserted. The branch is re-evaluated after the stall.
- mem_busy has highest priority:
  - Outputs: pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_flush=0, if_id_flush=0, stall_active unchanged from the FSM state.
  - FSM state, rem and stall_cycles hold (no decrement, no count).
  - When mem_busy=0 again, behaviour resumes exactly where it left off.
- stall_cycles increments by 1 on every clock edge where id_ex_flush=1. It saturates at 2^CNT_W-1 (no wrap).
- Reset (rst_n=0 at a clock edge):
  - state <= RUN, rem <= 0, stall_cycles <= 0.
  - While rst_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_freeze=0, stall_active=0.
  - Reset has priority over mem_busy.
  - A reset mid-stall aborts the stall; the first cycle after reset is RUN.
- The only registered state is FSM state, rem and stall_cycles. All other outputs are combinational from these plus the inputs.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=8, if_id_rs=8, uses_rs=1 -> one cycle with pc_write=0, id_ex_flush=1; the next cycle (inputs now non-matching) pc_write=1; stall_cycles=1.
- Branch on load: if_id_is_branch=1, id_ex_mem_read=1, id_ex_rd=5=if_id_rt, uses_rt=1 -> exactly 2 consecutive bubble cycles (second in STALL, regardless of inputs), then RUN; stall_cycles=2.
- Register 0: id_ex_mem_read=1, id_ex_rd=0, if_id_rs=0 -> no stall, pc_write=1.
- Flush vs stall: branch_taken=1 with load-use hazard active -> if_id_flush=0, id_ex_flush=1; next cycle, no hazard and branch_taken=1 -> if_id_flush=1, pc_write=1.
- mem_busy: mem_busy=1 for 3 cycles during the STALL state -> pipe_freeze=1, id_ex_flush=0, state and stall_cycles unchanged; after release, one more bubble, then RUN.
- Reset and saturation: rst_n=0 during STALL -> RUN next cycle, stall_cycles=0. With CNT_W=4, force 20 bubble cycles -> stall_cycles=15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall controller for the 5-stage MIPS pipeline: detects load-use and
// ID-branch hazards, sequences 1/2-bubble stalls, and honours memory wait freezes.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rs,
    input  logic             if_id_uses_rt,
    input  logic             if_id_is_branch,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_mem_read,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       rem;
    logic [1:0]       rem_nxt;
    logic [CNT_W-1:0] cnt;
    logic             m_ex;
    logic             m_mem;
    logic             h1;
    logic             h2;
    logic             stall;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    always_comb begin
        m_ex  = (id_ex_rd != 5'd0) &&
                ((if_id_uses_rs && (if_id_rs == id_ex_rd)) ||
                 (if_id_uses_rt && (if_id_rt == id_ex_rd)));
        m_mem = (ex_mem_rd != 5'd0) &&
                ((if_id_uses_rs && (if_id_rs == ex_mem_rd)) ||
                 (if_id_uses_rt && (if_id_rt == ex_mem_rd)));
        h2    = if_id_is_branch && id_ex_mem_read && m_ex;
        h1    = (id_ex_mem_read && m_ex) ||
                (if_id_is_branch && id_ex_reg_write && m_ex) ||
                (if_id_is_branch && ex_mem_mem_read && m_mem);
        stall = (state == STALL) || ((state == RUN) && (h1 || h2));
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            RUN: begin
                if (h2) begin
                    state_nxt = STALL;
                    rem_nxt   = 2'd1;
                end
            end
            STALL: begin
                rem_nxt = rem - 2'd1;
                if (rem_nxt == 2'd0) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = 2'd0;
            end
        endcase
    end

    // Reset outranks the memory freeze, which outranks hazard stalls.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        stall_active = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_freeze  = 1'b1;
            stall_active = stall;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_active = 1'b1;
        end else begin
            if_id_flush = branch_taken || jump;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
            cnt   <= '0;
        end else if (!mem_busy) begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (id_ex_flush && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stall_cycles = cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized
// traffic against a bubble-count reference model; a CNT_W=4 copy checks saturation.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic       if_id_uses_rs, if_id_uses_rt, if_id_is_branch;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic       branch_taken, jump, mem_busy;

    logic        a_pc, a_ifw, a_iff, a_idf, a_frz, a_sa;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifw, b_iff, b_idf, b_frz, b_sa;
    logic [3:0]  b_cnt;
    logic [5:0]  got16, got4;

    assign got16 = {a_pc, a_ifw, a_iff, a_idf, a_frz, a_sa};
    assign got4  = {b_pc, b_ifw, b_iff, b_idf, b_frz, b_sa};

    hazard_stall_ctrl dut16 (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .pipe_freeze(a_frz), .stall_active(a_sa), .stall_cycles(a_cnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .pipe_freeze(b_frz), .stall_active(b_sa), .stall_cycles(b_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: number of forced bubbles still owed, plus ideal counters.
    int pend   = 0;
    int exp_c16 = 0;
    int exp_c4  = 0;

    function automatic bit reads_reg(input logic [4:0] r);
        return (r != 5'd0) && ((if_id_uses_rs && if_id_rs == r) || (if_id_uses_rt && if_id_rt == r));
    endfunction

    function automatic int hazard_class();
        if (if_id_is_branch && id_ex_mem_read && reads_reg(id_ex_rd)) return 2;
        if ((id_ex_mem_read && reads_reg(id_ex_rd)) ||
            (if_id_is_branch && id_ex_reg_write && reads_reg(id_ex_rd)) ||
            (if_id_is_branch && ex_mem_mem_read && reads_reg(ex_mem_rd))) return 1;
        return 0;
    endfunction

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, stall_active}.
    function automatic logic [5:0] exp_vec();
        bit bub;
        if (!rst_n) return 6'b001100;
        bub = (pend > 0) || (hazard_class() != 0);
        if (mem_busy) return {4'b0000, 1'b1, bub};
        if (bub) return 6'b000101;
        return {2'b11, (branch_taken || jump), 3'b000};
    endfunction

    task automatic tick();
        bit bub;
        int hc;
        @(posedge clk);
        hc  = hazard_class();
        bub = (pend > 0) || (hc != 0);
        if (!rst_n) begin
            pend = 0; exp_c16 = 0; exp_c4 = 0;
        end else if (!mem_busy) begin
            if (bub) begin
                if (exp_c16 < 65535) exp_c16++;
                if (exp_c4 < 15) exp_c4++;
            end
            if (pend > 0) pend--;
            else if (hc == 2) pend = 1;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rst_n = 1'b1;
        if_id_rs = '0; if_id_rt = '0; id_ex_rd = '0; ex_mem_rd = '0;
        if_id_uses_rs = 0; if_id_uses_rt = 0; if_id_is_branch = 0;
        id_ex_mem_read = 0; id_ex_reg_write = 0; ex_mem_mem_read = 0;
        branch_taken = 0; jump = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use();
        id_ex_mem_read = 1; id_ex_rd = 5'd8; if_id_rs = 5'd8; if_id_uses_rs = 1;
    endtask

    task automatic set_branch_on_load();
        if_id_is_branch = 1; id_ex_mem_read = 1; id_ex_rd = 5'd5; if_id_rt = 5'd5; if_id_uses_rt = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0; mem_busy = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if (got16 !== 6'b001100) begin errors++; $display("[TB] FAIL reset_outputs: got %b want %b", got16, 6'b001100); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", a_cnt); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL reset_release: got %b want %b", got16, 6'b110000); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        @(negedge clk);
        checks++; if (got16 !== 6'b000101) begin errors++; $display("[TB] FAIL load_use_bubble: got %b want %b", got16, 6'b000101); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL load_use_resume: got %b want %b", got16, 6'b110000); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("[TB] FAIL load_use_count: got %0d want 1", a_cnt); end
        tick();
    endtask

    task automatic test_branch_on_load();
        do_reset();
        set_branch_on_load();
        @(negedge clk);
        checks++; if (got16 !== 6'b000101) begin errors++; $display("[TB] FAIL branch_load_bubble1: got %b want %b", got16, 6'b000101); end
        tick();
        clear_inputs();
        branch_taken = 1; jump = 1;
        @(negedge clk);
        checks++; if (got16 !== 6'b000101) begin errors++; $display("[TB] FAIL branch_load_bubble2: got %b want %b", got16, 6'b000101); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL branch_load_resume: got %b want %b", got16, 6'b110000); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("[TB] FAIL branch_load_count: got %0d want 2", a_cnt); end
        tick();
    endtask

    task automatic test_reg_zero();
        do_reset();
        id_ex_mem_read = 1; id_ex_rd = 5'd0; if_id_rs = 5'd0; if_id_uses_rs = 1;
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL reg_zero: got %b want %b", got16, 6'b110000); end
        tick();
    endtask

    task automatic test_flush_vs_stall();
        do_reset();
        set_load_use();
        branch_taken = 1;
        @(negedge clk);
        checks++; if (got16 !== 6'b000101) begin errors++; $display("[TB] FAIL flush_suppressed: got %b want %b", got16, 6'b000101); end
        tick();
        clear_inputs();
        branch_taken = 1;
        @(negedge clk);
        checks++; if (got16 !== 6'b111000) begin errors++; $display("[TB] FAIL flush_after_stall: got %b want %b", got16, 6'b111000); end
        tick();
    endtask

    task automatic test_mem_busy();
        do_reset();
        set_branch_on_load();
        tick();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (got16 !== 6'b000011) begin errors++; $display("[TB] FAIL busy_freeze: got %b want %b", got16, 6'b000011); end
            checks++; if (a_cnt !== 16'd1) begin errors++; $display("[TB] FAIL busy_count_hold: got %0d want 1", a_cnt); end
            tick();
        end
        mem_busy = 0;
        @(negedge clk);
        checks++; if (got16 !== 6'b000101) begin errors++; $display("[TB] FAIL busy_resume_bubble: got %b want %b", got16, 6'b000101); end
        tick();
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL busy_resume_run: got %b want %b", got16, 6'b110000); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("[TB] FAIL busy_final_count: got %0d want 2", a_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_branch_on_load();
        tick();
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        checks++; if (got16 !== 6'b001100) begin errors++; $display("[TB] FAIL midstall_reset_out: got %b want %b", got16, 6'b001100); end
        tick();
        rst_n = 1;
        @(negedge clk);
        checks++; if (got16 !== 6'b110000) begin errors++; $display("[TB] FAIL midstall_run: got %b want %b", got16, 6'b110000); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midstall_count: got %0d want 0", a_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (b_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_count4: got %0d want 15", b_cnt); end
        checks++; if (a_cnt !== 16'd20) begin errors++; $display("[TB] FAIL sat_count16: got %0d want 20", a_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] want, mask;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n           = ($urandom_range(0, 99) >= 3);
            if_id_rs        = 5'($urandom_range(0, 3));
            if_id_rt        = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            ex_mem_rd       = 5'($urandom_range(0, 3));
            if_id_uses_rs   = 1'($urandom);
            if_id_uses_rt   = 1'($urandom);
            if_id_is_branch = 1'($urandom);
            id_ex_mem_read  = 1'($urandom);
            id_ex_reg_write = 1'($urandom);
            ex_mem_mem_read = 1'($urandom);
            branch_taken    = ($urandom_range(0, 3) == 0);
            jump            = ($urandom_range(0, 7) == 0);
            mem_busy        = ($urandom_range(0, 99) < 20);
            @(negedge clk);
            want = exp_vec();
            mask = (rst_n && mem_busy && pend == 0) ? 6'b111110 : 6'b111111;
            checks++; if ((got16 & mask) !== (want & mask)) begin errors++; $display("[TB] FAIL rand_out16 cyc %0d: got %b want %b", i, got16, want); end
            checks++; if ((got4 & mask) !== (want & mask)) begin errors++; $display("[TB] FAIL rand_out4 cyc %0d: got %b want %b", i, got4, want); end
            checks++; if (a_cnt !== exp_c16[15:0]) begin errors++; $display("[TB] FAIL rand_cnt16 cyc %0d: got %0d want %0d", i, a_cnt, exp_c16); end
            checks++; if (b_cnt !== exp_c4[3:0]) begin errors++; $display("[TB] FAIL rand_cnt4 cyc %0d: got %0d want %0d", i, b_cnt, exp_c4); end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_on_load();
        test_reg_zero();
        test_flush_vs_stall();
        test_mem_busy();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
